// File: rtl/btb_update_ctrl.sv
// -----------------------------------------------------------------------------
// btb_update_ctrl
//
// Producer side of the dual-bank BTB update path. Resolved branches are
// reduced to the BTB-relevant events (mispredicted JALR outside debug mode).
// These events are queued in a small FIFO and issued as at most one
// btb_update_t per cycle toward the bank-select mux.
//
// The block also owns the checkpoint-mode bit that steers the mux. A mode
// change first drains every pending update into the old bank. Only after
// that drain does the mode flip.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   flush_i              discard queued updates
//   debug_mode_i         block acceptance of new updates
//   res_valid_i          resolved branch valid
//   res_pc_i             PC of the resolved branch
//   res_target_i         resolved target address
//   res_mispredict_i     branch was mispredicted
//   res_is_jalr_i        branch is an indirect jump
//   ckpt_req_i           requested checkpoint mode (level)
//   btb_update_o         {valid, pc, target_address} to the bank-select mux
//   ckpt_mode_o          current checkpoint mode
//   ckpt_busy_o          mode switch pending
//   drop_cnt_o           saturating count of qualifying events not enqueued
// -----------------------------------------------------------------------------

package riscv;
  localparam int unsigned VLEN = 64;
endpackage

package ariane_pkg;
  typedef struct packed {
    logic                   valid;
    logic [riscv::VLEN-1:0] pc;
    logic [riscv::VLEN-1:0] target_address;
  } btb_update_t;
endpackage

module btb_update_ctrl #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    flush_i,
  input  logic                    debug_mode_i,
  input  logic                    res_valid_i,
  input  logic [riscv::VLEN-1:0]  res_pc_i,
  input  logic [riscv::VLEN-1:0]  res_target_i,
  input  logic                    res_mispredict_i,
  input  logic                    res_is_jalr_i,
  input  logic                    ckpt_req_i,
  output ariane_pkg::btb_update_t btb_update_o,
  output logic                    ckpt_mode_o,
  output logic                    ckpt_busy_o,
  output logic [7:0]              drop_cnt_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  localparam logic [PtrW:0]   CntFull = (PtrW+1)'(DEPTH);
  localparam logic [PtrW:0]   CntOne  = (PtrW+1)'(1);
  localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);

  localparam logic [1:0] RUN    = 2'd0;
  localparam logic [1:0] DRAIN  = 2'd1;
  localparam logic [1:0] SWITCH = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [PtrW-1:0]        wptr_q, rptr_q;
  logic [PtrW:0]          cnt_q, cnt_d;
  logic                   mode_q;
  logic [7:0]             drop_q;

  logic [riscv::VLEN-1:0] pc_mem  [DEPTH];
  logic [riscv::VLEN-1:0] tgt_mem [DEPTH];

  logic qual, full, empty, enq, deq, drop;

  assign qual  = res_valid_i && res_mispredict_i && res_is_jalr_i && !debug_mode_i;
  assign full  = (cnt_q == CntFull);
  assign empty = (cnt_q == '0);

  // A flush discards the head as well. Nothing is issued in the flush cycle.
  assign deq  = !empty && (state_q != SWITCH) && !flush_i;
  // No full-bypass: the full check uses the count before this cycle's pop.
  assign enq  = qual && (state_q == RUN) && !full && !flush_i;
  // A qualifying, unflushed event that is not enqueued was either rejected
  // by a full FIFO or arrived outside RUN.
  assign drop = qual && !flush_i && !enq;

  always_comb begin
    btb_update_o = '0;
    if (deq) begin
      btb_update_o.valid          = 1'b1;
      btb_update_o.pc             = pc_mem[rptr_q];
      btb_update_o.target_address = tgt_mem[rptr_q];
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (flush_i) begin
      cnt_d = '0;
    end else begin
      unique case ({enq, deq})
        2'b10:   cnt_d = cnt_q + CntOne;
        2'b01:   cnt_d = cnt_q - CntOne;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // No enqueue happens in DRAIN, so cnt_d == 0 covers both cases.
  // One case is the last entry popping this cycle. The other is a flush.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (ckpt_req_i != mode_q) state_d = DRAIN;
      end
      DRAIN: begin
        if (ckpt_req_i == mode_q) state_d = RUN;
        else if (cnt_d == '0)     state_d = SWITCH;
      end
      SWITCH:  state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RUN;
      cnt_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      mode_q  <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (flush_i) begin
        wptr_q <= '0;
        rptr_q <= '0;
      end else begin
        if (enq) wptr_q <= wptr_q + PtrOne;
        if (deq) rptr_q <= rptr_q + PtrOne;
      end
      if (state_q == SWITCH)       mode_q <= ~mode_q;
      if (drop && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
    end
  end

  // The storage array has no reset. The count gates every read.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      pc_mem[wptr_q]  <= res_pc_i;
      tgt_mem[wptr_q] <= res_target_i;
    end
  end

  assign ckpt_mode_o = mode_q;
  assign ckpt_busy_o = (state_q != RUN);
  assign drop_cnt_o  = drop_q;

endmodule

// File: tb/tb_btb_update_ctrl.sv
// -----------------------------------------------------------------------------
// tb_btb_update_ctrl
//
// Self-checking bench for btb_update_ctrl. A transaction-level reference model
// holds the pending updates in a queue, together with drain/switch flags and
// a drop tally. The model predicts every output in every cycle.
// -----------------------------------------------------------------------------

module tb_btb_update_ctrl;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned VL    = riscv::VLEN;

  logic                    clk_i;
  logic                    rst_ni;
  logic                    flush_i;
  logic                    debug_mode_i;
  logic                    res_valid_i;
  logic [VL-1:0]           res_pc_i;
  logic [VL-1:0]           res_target_i;
  logic                    res_mispredict_i;
  logic                    res_is_jalr_i;
  logic                    ckpt_req_i;
  ariane_pkg::btb_update_t btb_update_o;
  logic                    ckpt_mode_o;
  logic                    ckpt_busy_o;
  logic [7:0]              drop_cnt_o;

  btb_update_ctrl #(.DEPTH(DEPTH)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .flush_i          (flush_i),
    .debug_mode_i     (debug_mode_i),
    .res_valid_i      (res_valid_i),
    .res_pc_i         (res_pc_i),
    .res_target_i     (res_target_i),
    .res_mispredict_i (res_mispredict_i),
    .res_is_jalr_i    (res_is_jalr_i),
    .ckpt_req_i       (ckpt_req_i),
    .btb_update_o     (btb_update_o),
    .ckpt_mode_o      (ckpt_mode_o),
    .ckpt_busy_o      (ckpt_busy_o),
    .drop_cnt_o       (drop_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  typedef struct packed {
    logic [VL-1:0] pc;
    logic [VL-1:0] tgt;
  } ent_t;

  ent_t q[$];
  bit   m_drain;
  bit   m_switch;
  bit   m_mode;
  int   m_drops;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_drain  = 1'b0;
    m_switch = 1'b0;
    m_mode   = 1'b0;
    m_drops  = 0;
  endtask

  // Drive one cycle of inputs and compare all outputs against the model.
  // Then advance the model across the clock edge.
  task automatic cycle(input bit v, input bit mp, input bit jr,
                       input logic [VL-1:0] pc, input logic [VL-1:0] tg,
                       input bit req, input bit fl, input bit dbg);
    bit   ev;
    bit   qual;
    bit   acc;
    ent_t e;
    @(negedge clk_i);
    res_valid_i      = v;
    res_mispredict_i = mp;
    res_is_jalr_i    = jr;
    res_pc_i         = pc;
    res_target_i     = tg;
    ckpt_req_i       = req;
    flush_i          = fl;
    debug_mode_i     = dbg;
    #1;
    ev = (q.size() > 0) && !m_switch && !fl;
    chk("valid",  64'(btb_update_o.valid), 64'(ev));
    chk("pc",     btb_update_o.pc,             ev ? q[0].pc  : '0);
    chk("target", btb_update_o.target_address, ev ? q[0].tgt : '0);
    chk("mode",   64'(ckpt_mode_o), 64'(m_mode));
    chk("busy",   64'(ckpt_busy_o), 64'(m_drain || m_switch));
    chk("drops",  64'(drop_cnt_o),  64'(m_drops));
    @(posedge clk_i);
    qual = v && mp && jr && !dbg;
    acc  = qual && !m_drain && !m_switch && (q.size() < DEPTH) && !fl;
    if (ev) void'(q.pop_front());
    if (fl) q.delete();
    if (acc) begin
      e.pc  = pc;
      e.tgt = tg;
      q.push_back(e);
    end
    if (qual && !fl && !acc && m_drops < 255) m_drops++;
    if (m_switch) begin
      m_mode   = !m_mode;
      m_switch = 1'b0;
    end else if (m_drain) begin
      if (req == m_mode) m_drain = 1'b0;
      else if (fl || q.size() == 0) begin
        m_drain  = 1'b0;
        m_switch = 1'b1;
      end
    end else if (req != m_mode) begin
      m_drain = 1'b1;
    end
  endtask

  task automatic idle(input bit req);
    cycle(1'b0, 1'b0, 1'b0, '0, '0, req, 1'b0, 1'b0);
  endtask

  task automatic ev_q(input logic [VL-1:0] pc, input logic [VL-1:0] tg, input bit req);
    cycle(1'b1, 1'b1, 1'b1, pc, tg, req, 1'b0, 1'b0);
  endtask

  function automatic logic [VL-1:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  bit req;

  initial begin
    rst_ni           = 1'b0;
    flush_i          = 1'b0;
    debug_mode_i     = 1'b0;
    res_valid_i      = 1'b0;
    res_pc_i         = '0;
    res_target_i     = '0;
    res_mispredict_i = 1'b0;
    res_is_jalr_i    = 1'b0;
    ckpt_req_i       = 1'b0;
    model_reset();
    repeat (2) @(negedge clk_i);
    #1;
    chk("rst_valid", 64'(btb_update_o.valid), 64'(0));
    chk("rst_word",  64'(btb_update_o.pc | btb_update_o.target_address), 64'(0));
    chk("rst_mode",  64'(ckpt_mode_o), 64'(0));
    chk("rst_busy",  64'(ckpt_busy_o), 64'(0));
    chk("rst_drops", 64'(drop_cnt_o),  64'(0));
    @(negedge clk_i);
    rst_ni = 1'b1;
    req = 1'b0;

    // Single update, followed by events that do not qualify.
    idle(req);
    ev_q(64'h1000, 64'h2000, req);
    idle(req);
    idle(req);
    cycle(1'b1, 1'b0, 1'b1, 64'h3000, 64'h4000, req, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 64'h5000, 64'h6000, req, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 64'h7000, 64'h8000, req, 1'b0, 1'b0);
    idle(req);

    // Back-to-back stream.
    for (int i = 0; i < 6; i++) ev_q(64'(32'h100 * (i + 1)), 64'(32'h9000 + i), req);
    repeat (3) idle(req);

    // Debug mode blocks acceptance and counting.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b1, rnd64(), rnd64(), req, 1'b0, 1'b1);
    idle(req);

    // Mode switch, with events arriving during the drain.
    ev_q(64'hA000, 64'hB000, req);
    ev_q(64'hA100, 64'hB100, req);
    req = 1'b1;
    ev_q(64'hA200, 64'hB200, req);
    ev_q(64'hA300, 64'hB300, req);
    ev_q(64'hA400, 64'hB400, req);
    repeat (3) idle(req);

    // Abort: the request pulses away from the current mode and back.
    ev_q(64'hC000, 64'hD000, req);
    ev_q(64'hC100, 64'hD100, 1'b0);
    idle(req);
    repeat (3) idle(req);

    // Flush during a drain.
    ev_q(64'hE000, 64'hF000, req);
    req = 1'b0;
    ev_q(64'hE100, 64'hF100, req);
    cycle(1'b1, 1'b1, 1'b1, 64'hE200, 64'hF200, req, 1'b1, 1'b0);
    repeat (3) idle(req);

    // Saturating drop counter: keep the request opposite the mode.
    // The block then cycles through RUN/DRAIN/SWITCH and drops most events.
    for (int i = 0; i < 450; i++) begin
      req = !m_mode;
      ev_q(rnd64(), rnd64(), req);
    end
    chk("drop_sat", 64'(drop_cnt_o), 64'(255));
    req = m_mode;
    repeat (4) idle(req);

    // Reset clears the drop counter, ahead of the random phase.
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    model_reset();
    chk("rst2_drops", 64'(drop_cnt_o), 64'(0));
    @(negedge clk_i);
    rst_ni = 1'b1;
    req = 1'b0;

    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(15) == 0) req = !req;
      cycle($urandom_range(3) != 0, $urandom_range(3) != 0, $urandom_range(3) != 0,
            rnd64(), rnd64(), req, $urandom_range(19) == 0, $urandom_range(15) == 0);
    end
    req = m_mode;
    repeat (4) idle(req);

    // Asynchronous reset in the middle of a drain, with mode 1 and an entry queued.
    if (!m_mode) begin
      req = 1'b1;
      idle(req);
      repeat (3) idle(req);
    end
    req = 1'b0;
    ev_q(64'h1234, 64'h5678, req);
    @(negedge clk_i);
    res_valid_i = 1'b0;
    #1;
    chk("pre_rst_busy",  64'(ckpt_busy_o), 64'(1));
    chk("pre_rst_valid", 64'(btb_update_o.valid), 64'(1));
    chk("pre_rst_mode",  64'(ckpt_mode_o), 64'(1));
    rst_ni = 1'b0;
    #1;
    model_reset();
    chk("arst_valid", 64'(btb_update_o.valid), 64'(0));
    chk("arst_mode",  64'(ckpt_mode_o), 64'(0));
    chk("arst_busy",  64'(ckpt_busy_o), 64'(0));
    chk("arst_drops", 64'(drop_cnt_o),  64'(0));
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (3) idle(req);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
